tmds_channel_decoder: RTL and testbench
=======================================

// Module: tmds_channel_decoder
// PURPOSE
// - Receive-side counterpart of the TMDS encoder: one TMDS channel, pixel-clock domain.
// - Takes unaligned 10-bit words from an external 1:10 deserializer and finds symbol alignment by hunting for control tokens.
// - Decodes each aligned symbol to 8-bit video data, or to a 2-bit control value (ctl[1]=vsync, ctl[0]=hsync on blue).
// - Three instances sit behind the deserializers of an HDMI/DVI input top.
// PARAMETERS
// - CTRL_RUN      8     consecutive control tokens required to declare lock
// - SEARCH_DWELL  2048  cycles spent at one bit offset before slipping (> 1650-pixel line)
// - LOSS_TIMEOUT  4096  cycles in lock without a CTRL_RUN token run -> drop lock
// PORTS
// - i_clk      in   1  pixel clock
// - i_rst      in   1  synchronous, active-high reset
// - i_raw      in  10  deserialized word, unaligned; bit 0 = first bit on the wire
// - o_data     out  8  decoded pixel byte
// - o_control  out  2  last decoded control value (held during data periods)
// - o_de       out  1  1 = o_data valid video symbol; 0 = control/blanking
// - o_locked   out  1  alignment acquired
// - o_offset   out  4  current bit offset, 0..9
// - o_slip     out  1  one-cycle pulse on each offset advance
// BEHAVIOUR
// - Reset is synchronous, active-high; one clock only.
// - Reset values: all outputs 0; state SEARCH; offset 0; all counters 0.
// - Reset mid-operation returns to these values on the next edge; the previous word register is cleared.
// - Alignment window: window[19:0] = {i_raw, raw_prev}, where raw_prev is i_raw registered.
// - Candidate word: window[offset +: 10].
// - Stage 1 registers the candidate word (sym_q).
// - Stage 2 registers the decode outputs. Latency is 2 cycles from the i_raw word that completes the symbol.
// - Tokens (10-bit values): 00 = 1101010100, 01 = 0010101011, 10 = 0101010100, 11 = 1010101011.
//   - A token sets o_de=0 and o_control=ctl; o_data holds its value.
// - Non-token word w: d = w[9] ? ~w[7:0] : w[7:0].
//   - out[0] = d[0].
//   - out[i] = w[8] ? d[i]^d[i-1] : ~(d[i]^d[i-1]).
//   - o_de=1, o_data=out.
// - While not locked: o_de forced 0 and o_data forced 0; o_control still updates from tokens.
// - FSM SEARCH:
//   - run_cnt counts consecutive tokens in sym_q; it clears on any non-token.
//   - dwell_cnt increments every cycle.
//   - run_cnt reaching CTRL_RUN -> LOCKED; o_locked=1 on the next edge.
//   - dwell_cnt reaching SEARCH_DWELL-1 -> offset = (offset==9) ? 0 : offset+1; o_slip pulse; dwell_cnt and run_cnt clear.
//   - Lock and dwell expiry in the same cycle: lock wins, no slip.
//   - A slip invalidates sym_q for one cycle; run counting restarts.
// - FSM LOCKED:
//   - loss_cnt increments and clears whenever run_cnt reaches CTRL_RUN.
//   - loss_cnt reaching LOSS_TIMEOUT -> SEARCH at the same offset with dwell restarted; o_locked=0 on the next edge.
// - Counter widths: $clog2(PARAM+1); counters saturate, never wrap.
// STRUCTURE
// - tmds_pkg: the four token constants, ctl<->token mapping function, state enum {SEARCH, LOCKED}.
// - tmds_pkg is shared with the TMDS encoder.
// - Sub-module tmds_symbol_decode (combinational): 10-bit word -> {is_token, ctl[1:0], data[7:0]}.
// - Alignment FSM, counters and pipeline registers stay in this module.
// TESTING
// - Reset: i_rst=1 for 5 cycles with random i_raw -> all outputs 0, o_offset=0; o_slip never pulses.
// - Offset 0: 20 x token 00, then encoded 8'hA5 x4, then token 11.
//   - o_locked rises at cycle CTRL_RUN+3.
//   - o_de=1 with o_data=A5 for exactly 4 cycles.
//   - o_control=11 follows.
// - Misalignment: bitstream led by 3 junk bits, 720p line (370 tokens, 1280 data).
//   - o_offset settles at 3; the slip count before lock is exactly 3.
//   - All data matches the reference encoder output.
// - Decode sweep: values 0..255 through the encoder in both running-disparity states (inverted and non-inverted words).
//   - Every o_data equals the input; o_de=1 each cycle.
// - Lock loss: after lock, send only data words.
//   - o_locked falls exactly LOSS_TIMEOUT+1 cycles after the last token run completed.
//   - Re-lock occurs at the same offset with no slip.
// - Reset mid-search at offset 6: o_offset=0 and o_locked=0 on the next edge; lock is reacquired afterwards.

Source files
------------

// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: control tokens, ctl<->token mapping and the receive alignment states.
// Used by both the TMDS encoder and the channel decoder.
package tmds_pkg;

    localparam logic [9:0] TOKEN_00 = 10'b1101010100;
    localparam logic [9:0] TOKEN_01 = 10'b0010101011;
    localparam logic [9:0] TOKEN_10 = 10'b0101010100;
    localparam logic [9:0] TOKEN_11 = 10'b1010101011;

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } align_state_t;

    typedef struct packed {
        logic       is_token;
        logic [1:0] ctl;
    } token_match_t;

    function automatic logic [9:0] ctl_to_token(input logic [1:0] ctl);
        logic [9:0] tok;
        case (ctl)
            2'b00:   tok = TOKEN_00;
            2'b01:   tok = TOKEN_01;
            2'b10:   tok = TOKEN_10;
            default: tok = TOKEN_11;
        endcase
        return tok;
    endfunction

    function automatic token_match_t token_to_ctl(input logic [9:0] word);
        token_match_t m;
        m.is_token = 1'b1;
        m.ctl      = 2'b00;
        case (word)
            TOKEN_00: m.ctl = 2'b00;
            TOKEN_01: m.ctl = 2'b01;
            TOKEN_10: m.ctl = 2'b10;
            TOKEN_11: m.ctl = 2'b11;
            default:  m.is_token = 1'b0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/tmds_symbol_decode.sv
// Combinational decode of one aligned 10-bit TMDS symbol into a control token match
// or an 8-bit data byte (undo optional inversion, then undo XOR/XNOR chaining).
module tmds_symbol_decode
    import tmds_pkg::*;
(
    input  logic [9:0] sym,
    output logic       is_token,
    output logic [1:0] ctl,
    output logic [7:0] data
);

    token_match_t match;
    logic [7:0]   d;

    assign match    = token_to_ctl(sym);
    assign is_token = match.is_token;
    assign ctl      = match.ctl;

    assign d       = sym[9] ? ~sym[7:0] : sym[7:0];
    assign data[0] = d[0];

    // sym[8] selects whether the encoder chained with XOR (1) or XNOR (0)
    generate
        for (genvar gi = 1; gi < 8; gi++) begin : g_bit
            assign data[gi] = sym[8] ? (d[gi] ^ d[gi-1]) : ~(d[gi] ^ d[gi-1]);
        end
    endgenerate

endmodule

// File: rtl/tmds_channel_decoder.sv
// One TMDS receive channel: bit alignment by control-token hunting, then 2-stage symbol decode.
// Stage 1 captures the candidate word at the current offset, stage 2 registers the decoded outputs.
module tmds_channel_decoder
    import tmds_pkg::*;
#(
    parameter int CTRL_RUN     = 8,
    parameter int SEARCH_DWELL = 2048,
    parameter int LOSS_TIMEOUT = 4096
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [9:0] i_raw,
    output logic [7:0] o_data,
    output logic [1:0] o_control,
    output logic       o_de,
    output logic       o_locked,
    output logic [3:0] o_offset,
    output logic       o_slip
);

    localparam int RUN_W   = $clog2(CTRL_RUN + 1);
    localparam int DWELL_W = $clog2(SEARCH_DWELL + 1);
    localparam int LOSS_W  = $clog2(LOSS_TIMEOUT + 1);

    localparam logic [RUN_W-1:0]   RUN_MAX    = RUN_W'(CTRL_RUN);
    localparam logic [DWELL_W-1:0] DWELL_MAX  = DWELL_W'(SEARCH_DWELL);
    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(SEARCH_DWELL - 1);
    localparam logic [LOSS_W-1:0]  LOSS_MAX   = LOSS_W'(LOSS_TIMEOUT);

    logic [9:0]         raw_prev_reg;
    logic [19:0]        window;
    logic [9:0]         sym_reg;
    logic               sym_valid_reg;

    logic               sym_is_token;
    logic [1:0]         sym_ctl;
    logic [7:0]         sym_data;
    logic               sym_tok;

    align_state_t       state_reg, state_next;
    logic [3:0]         offset_reg, offset_next;
    logic [RUN_W-1:0]   run_cnt_reg, run_cnt_next;
    logic [DWELL_W-1:0] dwell_cnt_reg, dwell_cnt_next;
    logic [LOSS_W-1:0]  loss_cnt_reg, loss_cnt_next;
    logic               slip_reg, slip_next;

    logic [7:0]         data_reg;
    logic [1:0]         control_reg;
    logic               de_reg;

    assign window = {i_raw, raw_prev_reg};

    tmds_symbol_decode u_symbol_decode (
        .sym      (sym_reg),
        .is_token (sym_is_token),
        .ctl      (sym_ctl),
        .data     (sym_data)
    );

    assign sym_tok = sym_valid_reg & sym_is_token;

    always_comb begin
        state_next     = state_reg;
        offset_next    = offset_reg;
        dwell_cnt_next = dwell_cnt_reg;
        loss_cnt_next  = loss_cnt_reg;
        slip_next      = 1'b0;
        if (!sym_tok)
            run_cnt_next = '0;
        else if (run_cnt_reg == RUN_MAX)
            run_cnt_next = run_cnt_reg;
        else
            run_cnt_next = run_cnt_reg + RUN_W'(1);

        case (state_reg)
            SEARCH: begin
                if (dwell_cnt_reg != DWELL_MAX)
                    dwell_cnt_next = dwell_cnt_reg + DWELL_W'(1);
                // a completed token run takes priority over an expiring dwell
                if (run_cnt_reg == RUN_MAX) begin
                    state_next     = LOCKED;
                    dwell_cnt_next = '0;
                    loss_cnt_next  = '0;
                end else if (dwell_cnt_reg == DWELL_LAST) begin
                    offset_next    = (offset_reg == 4'd9) ? 4'd0 : offset_reg + 4'd1;
                    slip_next      = 1'b1;
                    dwell_cnt_next = '0;
                    run_cnt_next   = '0;
                end
            end
            LOCKED: begin
                if (run_cnt_reg == RUN_MAX)
                    loss_cnt_next = '0;
                else if (loss_cnt_reg != LOSS_MAX)
                    loss_cnt_next = loss_cnt_reg + LOSS_W'(1);
                if (loss_cnt_reg == LOSS_MAX) begin
                    state_next     = SEARCH;
                    dwell_cnt_next = '0;
                    loss_cnt_next  = '0;
                end
            end
            default: state_next = SEARCH;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            raw_prev_reg  <= '0;
            sym_reg       <= '0;
            sym_valid_reg <= 1'b0;
            state_reg     <= SEARCH;
            offset_reg    <= '0;
            run_cnt_reg   <= '0;
            dwell_cnt_reg <= '0;
            loss_cnt_reg  <= '0;
            slip_reg      <= 1'b0;
        end else begin
            raw_prev_reg  <= i_raw;
            sym_reg       <= window[offset_reg +: 10];
            // the word captured on a slip edge used the old offset
            sym_valid_reg <= ~slip_next;
            state_reg     <= state_next;
            offset_reg    <= offset_next;
            run_cnt_reg   <= run_cnt_next;
            dwell_cnt_reg <= dwell_cnt_next;
            loss_cnt_reg  <= loss_cnt_next;
            slip_reg      <= slip_next;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            data_reg    <= '0;
            control_reg <= '0;
            de_reg      <= 1'b0;
        end else begin
            if (sym_tok)
                control_reg <= sym_ctl;
            de_reg <= (state_next == LOCKED) && sym_valid_reg && !sym_is_token;
            if (state_next != LOCKED)
                data_reg <= '0;
            else if (sym_valid_reg && !sym_is_token)
                data_reg <= sym_data;
        end
    end

    assign o_data    = data_reg;
    assign o_control = control_reg;
    assign o_de      = de_reg;
    assign o_locked  = (state_reg == LOCKED);
    assign o_offset  = offset_reg;
    assign o_slip    = slip_reg;

endmodule

// File: tb/tb_tmds_channel_decoder.sv
// Directed self-checking bench for tmds_channel_decoder: reset, aligned lock, decode sweep,
// misaligned acquisition over 720p lines, lock loss/re-lock and reset during search.
module tb_tmds_channel_decoder;
    import tmds_pkg::*;

    localparam int CTRL_RUN     = 8;
    localparam int SEARCH_DWELL = 2048;
    localparam int LOSS_TIMEOUT = 4096;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] raw;
    logic [7:0] data;
    logic [1:0] control;
    logic       de;
    logic       locked;
    logic [3:0] offset;
    logic       slip;

    int         n_cmp = 0;
    int         n_bad = 0;
    int         cyc = 0;
    int         slip_cnt = 0;
    int         rd = 0;
    int         sh = 0;
    int         de_seen = 0;
    int         n_push = 0;
    int         lock_slips = 0;
    bit         sb_on = 1'b0;
    bit         lock_seen = 1'b0;
    logic [9:0] prev_sym = '0;
    logic [7:0] exp_q[$];

    tmds_channel_decoder #(
        .CTRL_RUN     (CTRL_RUN),
        .SEARCH_DWELL (SEARCH_DWELL),
        .LOSS_TIMEOUT (LOSS_TIMEOUT)
    ) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_raw     (raw),
        .o_data    (data),
        .o_control (control),
        .o_de      (de),
        .o_locked  (locked),
        .o_offset  (offset),
        .o_slip    (slip)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: cycle %0d reached time limit, required finish", cyc);
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference DVI encoder; mode 0 tracks running disparity, 1 forces plain, 2 forces inverted.
    task automatic tmds_encode(input logic [7:0] d, input int mode, output logic [9:0] q);
        logic [8:0] qm;
        int n1, n1q, n0q;
        n1 = $countones(d);
        qm[0] = d[0];
        if (n1 > 4 || (n1 == 4 && d[0] == 1'b0)) begin
            for (int i = 1; i < 8; i++) qm[i] = ~(qm[i-1] ^ d[i]);
            qm[8] = 1'b0;
        end else begin
            for (int i = 1; i < 8; i++) qm[i] = qm[i-1] ^ d[i];
            qm[8] = 1'b1;
        end
        n1q = $countones(qm[7:0]);
        n0q = 8 - n1q;
        if (mode == 1) begin
            q = {1'b0, qm};
        end else if (mode == 2) begin
            q = {1'b1, qm[8], ~qm[7:0]};
        end else if (rd == 0 || n1q == n0q) begin
            q  = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
            rd = rd + (qm[8] ? (n1q - n0q) : (n0q - n1q));
        end else if ((rd > 0 && n1q > n0q) || (rd < 0 && n0q > n1q)) begin
            q  = {1'b1, qm[8], ~qm[7:0]};
            rd = rd + 2 * int'(qm[8]) + (n0q - n1q);
        end else begin
            q  = {1'b0, qm[8], qm[7:0]};
            rd = rd - 2 * int'(!qm[8]) + (n1q - n0q);
        end
    endtask

    task automatic step(input logic [9:0] w);
        raw = w;
        @(posedge clk);
        #1;
        cyc++;
        if (slip) slip_cnt++;
        if (locked && !lock_seen) begin
            lock_seen  = 1'b1;
            lock_slips = slip_cnt;
        end
        if (sb_on && de) begin
            de_seen++;
            if (exp_q.size() == 0) check_eq("sb_underflow", 32'(exp_q.size()), 32'd1);
            else check_eq("sb_data", 32'(data), 32'(exp_q.pop_front()));
        end
    endtask

    // Serial stream led by sh junk bits, cut into 10-bit deserializer words.
    task automatic send_sym(input logic [9:0] s);
        logic [19:0] pair;
        pair     = {s, prev_sym};
        prev_sym = s;
        step(pair[(10 - sh) +: 10]);
    endtask

    task automatic send_line(input int ln);
        logic [9:0] w;
        logic [7:0] b;
        for (int i = 0; i < 370; i++) send_sym(TOKEN_00);
        for (int i = 0; i < 1280; i++) begin
            b = 8'((i * 37 + ln * 11) & 255);
            tmds_encode(b, 0, w);
            if (lock_seen) begin
                exp_q.push_back(b);
                n_push++;
            end
            send_sym(w);
        end
    endtask

    initial begin
        int s0, t_lock, de_cnt, t_de, t_fall;
        logic [9:0] w;

        rst = 1'b1;
        raw = '0;

        // reset with random input words
        s0 = slip_cnt;
        for (int i = 0; i < 5; i++) begin
            step(10'($urandom));
            check_eq("rst_outputs", 32'({data, control, de, locked, offset, slip}), 32'd0);
        end
        check_eq("rst_no_slip", 32'(slip_cnt - s0), 32'd0);
        $display("reset: outputs idle over 5 reset cycles");

        // aligned stream: 20 x token 00, 4 x A5, token 11
        rst = 1'b0;
        sh = 0;
        t_lock = 0;
        de_cnt = 0;
        for (int k = 1; k <= 20; k++) begin
            send_sym(TOKEN_00);
            if (locked && t_lock == 0) t_lock = k;
            if (!locked) check_eq("pre_lock_de", 32'(de), 32'd0);
        end
        check_eq("lock_cycle", 32'(t_lock), 32'(CTRL_RUN + 3));
        check_eq("ctl_in_run", 32'(control), 32'd0);
        check_eq("offset_aligned", 32'(offset), 32'd0);
        for (int k = 0; k < 8; k++) begin
            send_sym(k < 4 ? 10'h163 : TOKEN_11);
            if (de) begin
                de_cnt++;
                check_eq("a5_data", 32'(data), 32'hA5);
            end
        end
        check_eq("a5_de_count", 32'(de_cnt), 32'd4);
        check_eq("ctl_after_a5", 32'(control), 32'd3);
        check_eq("de_after_a5", 32'(de), 32'd0);
        check_eq("data_hold", 32'(data), 32'hA5);
        $display("offset0: lock at cycle %0d, %0d data cycles", t_lock, de_cnt);

        // decode sweep in both disparity polarities
        sb_on = 1'b1;
        de_seen = 0;
        exp_q.delete();
        for (int v = 0; v < 256; v++) begin
            for (int m = 1; m <= 2; m++) begin
                tmds_encode(8'(v), m, w);
                exp_q.push_back(8'(v));
                send_sym(w);
            end
        end
        for (int k = 0; k < 6; k++) send_sym(TOKEN_00);
        check_eq("sweep_de_count", 32'(de_seen), 32'd512);
        check_eq("sweep_queue_left", 32'(exp_q.size()), 32'd0);
        check_eq("sweep_locked", 32'(locked), 32'd1);
        $display("sweep: %0d words decoded", de_seen);

        // stream led by 3 junk bits, repeated 720p lines
        rst = 1'b1;
        step('0);
        step('0);
        rst = 1'b0;
        sh = 3;
        prev_sym = 10'b1010000000;
        rd = 0;
        lock_seen = 1'b0;
        n_push = 0;
        de_seen = 0;
        exp_q.delete();
        s0 = slip_cnt;
        for (int ln = 0; ln < 8 && !lock_seen; ln++) send_line(ln);
        check_eq("mis_lock_seen", 32'(lock_seen), 32'd1);
        check_eq("mis_slips", 32'(lock_slips - s0), 32'd3);
        check_eq("mis_offset", 32'(offset), 32'd3);
        send_line(100);
        for (int k = 0; k < 6; k++) send_sym(TOKEN_00);
        check_eq("mis_de_vs_push", 32'(de_seen), 32'(n_push));
        check_eq("mis_queue_left", 32'(exp_q.size()), 32'd0);
        check_eq("mis_full_line", 32'(n_push >= 1280), 32'd1);
        check_eq("mis_no_extra_slip", 32'(slip_cnt - s0), 32'd3);
        $display("misalign: offset %0d, %0d slips, %0d data words", offset, lock_slips - s0, de_seen);

        // lock loss on a data-only stream, then re-lock
        sb_on = 1'b0;
        for (int k = 0; k < 20; k++) send_sym(TOKEN_00);
        check_eq("loss_pre_locked", 32'(locked), 32'd1);
        t_de = -1;
        t_fall = -1;
        for (int i = 0; i < 5000 && t_fall < 0; i++) begin
            tmds_encode(8'(i * 13), 0, w);
            send_sym(w);
            if (de && t_de < 0) t_de = cyc;
            if (!locked && t_fall < 0) t_fall = cyc;
        end
        check_eq("loss_de_seen", 32'(t_de >= 0), 32'd1);
        check_eq("loss_fall_seen", 32'(t_fall >= 0), 32'd1);
        check_eq("loss_delay", 32'(t_fall - t_de), 32'(LOSS_TIMEOUT + 1));
        s0 = slip_cnt;
        t_lock = -1;
        for (int k = 0; k < 40 && t_lock < 0; k++) begin
            send_sym(TOKEN_01);
            if (locked) t_lock = k;
        end
        check_eq("relock", 32'(locked), 32'd1);
        check_eq("relock_offset", 32'(offset), 32'd3);
        check_eq("relock_no_slip", 32'(slip_cnt - s0), 32'd0);
        check_eq("relock_ctl", 32'(control), 32'd1);
        $display("lossrelock: fall after %0d cycles, relock after %0d tokens", t_fall - t_de, t_lock + 1);

        // reset while searching at offset 6
        rst = 1'b1;
        step('0);
        step('0);
        rst = 1'b0;
        sh = 7;
        s0 = slip_cnt;
        for (int i = 0; i < 7 * SEARCH_DWELL + 200 && offset != 4'd6; i++) send_sym(TOKEN_00);
        check_eq("search_offset6", 32'(offset), 32'd6);
        check_eq("search_slips6", 32'(slip_cnt - s0), 32'd6);
        check_eq("search_unlocked", 32'(locked), 32'd0);
        rst = 1'b1;
        send_sym(TOKEN_00);
        check_eq("midrst_offset", 32'(offset), 32'd0);
        check_eq("midrst_locked", 32'(locked), 32'd0);
        check_eq("midrst_slip", 32'(slip), 32'd0);
        rst = 1'b0;
        sh = 0;
        t_lock = -1;
        for (int k = 0; k < 40 && t_lock < 0; k++) begin
            send_sym(TOKEN_10);
            if (locked) t_lock = k;
        end
        check_eq("midrst_relock", 32'(locked), 32'd1);
        check_eq("midrst_relock_offset", 32'(offset), 32'd0);
        $display("midreset: relock after %0d tokens at offset %0d", t_lock + 1, offset);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
